// File: rtl/doorlock_pkg.sv
// Shared constants and serializer state encoding for the doorlock datapath.
package doorlock_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } ser_state_e;

endpackage

// File: rtl/doorlock_digit_serializer_if.sv
// Digit stream handshake: source drives valid/data/last, sink drives ready.
interface doorlock_digit_serializer_if #(
  parameter int DW = 4
);
  logic          dig_valid;
  logic          dig_ready;
  logic [DW-1:0] dig_data;
  logic          dig_last;

  modport master (output dig_valid, output dig_data, output dig_last, input dig_ready);
  modport slave  (input dig_valid, input dig_data, input dig_last, output dig_ready);
endinterface

// File: rtl/doorlock_digit_mux.sv
// Combinational slice selector and blank-skipping search over one stored code.
module doorlock_digit_mux #(
  parameter int              DW         = 4,
  parameter int              DIGITS     = 4,
  parameter bit              OLDEST_1ST = 1'b1,
  parameter bit              SKIP_BLANK = 1'b1,
  parameter logic [DW-1:0]   BLANK_CODE = 4'hF,
  parameter int              IW         = 2
) (
  input  logic [DIGITS*DW-1:0] code,
  input  logic [IW-1:0]        idx,
  output logic                 first_ok,
  output logic [IW-1:0]        first_idx,
  output logic [DW-1:0]        first_digit,
  output logic                 first_last,
  output logic [IW-1:0]        nxt_idx,
  output logic [DW-1:0]        nxt_digit,
  output logic                 nxt_last
);

  // keep[p] refers to emission position p, not slice p
  logic [DIGITS-1:0] keep;
  logic              nxt_found;
  int                cur_p;
  int                sl;

  always_comb begin
    keep       = '0;
    first_ok   = 1'b0;
    first_idx  = '0;
    first_last = 1'b1;
    nxt_found  = 1'b0;
    nxt_idx    = '0;
    nxt_last   = 1'b1;
    sl         = 0;
    cur_p      = OLDEST_1ST ? (DIGITS - 1 - int'(idx)) : int'(idx);

    for (int p = 0; p < DIGITS; p++) begin
      sl      = OLDEST_1ST ? (DIGITS - 1 - p) : p;
      keep[p] = !(SKIP_BLANK && (code[sl*DW +: DW] == BLANK_CODE));
    end

    for (int p = 0; p < DIGITS; p++) begin
      sl = OLDEST_1ST ? (DIGITS - 1 - p) : p;
      if (keep[p]) begin
        if (!first_ok) begin
          first_ok  = 1'b1;
          first_idx = IW'(sl);
        end else begin
          first_last = 1'b0;
        end
        if (p > cur_p) begin
          if (!nxt_found) begin
            nxt_found = 1'b1;
            nxt_idx   = IW'(sl);
          end else begin
            nxt_last = 1'b0;
          end
        end
      end
    end

    first_digit = code[int'(first_idx)*DW +: DW];
    nxt_digit   = code[int'(nxt_idx)*DW +: DW];
  end

endmodule

// File: rtl/doorlock_digit_serializer.sv
// Parallel-in / serial-out digit serializer: captures a code, replays it per handshake.
//  state | meaning
//  IDLE  | waiting for load; shadow holds the previous code
//  SEND  | dig_valid high, presenting shadow slice at idx
//  DONE  | one-cycle done pulse, then back to IDLE
module doorlock_digit_serializer
  import doorlock_pkg::*;
#(
  parameter int            DW         = DIGIT_W,
  parameter int            DIGITS     = NUM_DIGITS,
  parameter bit            OLDEST_1ST = 1'b1,
  parameter bit            SKIP_BLANK = 1'b1,
  parameter logic [DW-1:0] BLANK_CODE = doorlock_pkg::BLANK_CODE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] code_in,
  doorlock_digit_serializer_if.master dig,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  ser_state_e             state_q, state_d;
  logic [DIGITS*DW-1:0]   shadow_q, shadow_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   valid_q, valid_d;
  logic [DW-1:0]          data_q, data_d;
  logic                   last_q, last_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [DIGITS*DW-1:0]   mux_code;
  logic                   first_ok, first_last, nxt_last;
  logic [IW-1:0]          first_idx, nxt_idx;
  logic [DW-1:0]          first_digit, nxt_digit;

  // In IDLE the search runs on the incoming code so capture and first digit land together
  assign mux_code = (state_q == IDLE) ? code_in : shadow_q;

  doorlock_digit_mux #(
    .DW         (DW),
    .DIGITS     (DIGITS),
    .OLDEST_1ST (OLDEST_1ST),
    .SKIP_BLANK (SKIP_BLANK),
    .BLANK_CODE (BLANK_CODE),
    .IW         (IW)
  ) u_mux (
    .code        (mux_code),
    .idx         (idx_q),
    .first_ok    (first_ok),
    .first_idx   (first_idx),
    .first_digit (first_digit),
    .first_last  (first_last),
    .nxt_idx     (nxt_idx),
    .nxt_digit   (nxt_digit),
    .nxt_last    (nxt_last)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    data_d   = data_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = done_q;

    if (ce) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            shadow_d = code_in;
            idx_d    = first_idx;
            busy_d   = 1'b1;
            if (first_ok) begin
              state_d = SEND;
              valid_d = 1'b1;
              data_d  = first_digit;
              last_d  = first_last;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        SEND: begin
          if (valid_q && dig.dig_ready) begin
            if (last_q) begin
              state_d = DONE;
              valid_d = 1'b0;
              last_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              idx_d  = nxt_idx;
              data_d = nxt_digit;
              last_d = nxt_last;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign dig.dig_valid = valid_q;
  assign dig.dig_data  = data_q;
  assign dig.dig_last  = last_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_doorlock_digit_serializer.sv
// Directed vector bench for doorlock_digit_serializer (oldest-first and newest-first builds).
module tb_doorlock_digit_serializer;

  logic        clk = 1'b0;
  logic        rst, ce, load;
  logic [15:0] code_in;
  logic        busy_a, done_a, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  doorlock_digit_serializer_if #(.DW(4)) if_a ();
  doorlock_digit_serializer_if #(.DW(4)) if_b ();

  doorlock_digit_serializer dut_a (
    .clk(clk), .rst(rst), .ce(ce), .load(load), .code_in(code_in),
    .dig(if_a.master), .busy(busy_a), .done(done_a)
  );

  doorlock_digit_serializer #(.OLDEST_1ST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .ce(ce), .load(load), .code_in(code_in),
    .dig(if_b.master), .busy(busy_b), .done(done_b)
  );

  typedef struct {
    logic        rst, ce, load;
    logic [15:0] code;
    logic        rdy;
    logic        ev, dchk;
    logic [3:0]  ed;
    logic        el, eb, edn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic c, logic l, logic [15:0] cd, logic rd,
                              logic ev, logic dchk, logic [3:0] ed, logic el,
                              logic eb, logic edn);
    vec_t v;
    v.rst = r; v.ce = c; v.load = l; v.code = cd; v.rdy = rd;
    v.ev = ev; v.dchk = dchk; v.ed = ed; v.el = el; v.eb = eb; v.edn = edn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_b[4];
  logic [3:0] got_b[4];
  logic [3:0] got_last;
  int         n_b;
  logic       seen_done;

  initial begin
    rst = 1'b1; ce = 1'b1; load = 1'b0; code_in = 16'h0;
    if_a.dig_ready = 1'b0; if_b.dig_ready = 1'b0;
    step(); step();

    chk("reset valid_a", {31'd0, if_a.dig_valid}, 32'd0);
    chk("reset data_a",  {28'd0, if_a.dig_data},  32'd0);
    chk("reset last_a",  {31'd0, if_a.dig_last},  32'd0);
    chk("reset busy_a",  {31'd0, busy_a},         32'd0);
    chk("reset done_a",  {31'd0, done_a},         32'd0);
    chk("reset valid_b", {31'd0, if_b.dig_valid}, 32'd0);
    chk("reset busy_b",  {31'd0, busy_b},         32'd0);
    rst = 1'b0;

    // rst ce ld code rdy | valid dchk data last busy done  (expected after the edge)
    // basic oldest-first 1234
    vecs.push_back(mk(0,1,1,16'h1234,1, 1,1,4'h1,0, 1,0));
    vecs.push_back(mk(0,1,0,16'h1234,1, 1,1,4'h2,0, 1,0));
    vecs.push_back(mk(0,1,0,16'h1234,1, 1,1,4'h3,0, 1,0));
    vecs.push_back(mk(0,1,0,16'h1234,1, 1,1,4'h4,1, 1,0));
    vecs.push_back(mk(0,1,0,16'h1234,1, 0,0,4'h0,0, 1,1));
    vecs.push_back(mk(0,1,0,16'h1234,1, 0,0,4'h0,0, 0,0));
    // blank skipping 12F4 -> 1,2,4
    vecs.push_back(mk(0,1,1,16'h12F4,1, 1,1,4'h1,0, 1,0));
    vecs.push_back(mk(0,1,0,16'h12F4,1, 1,1,4'h2,0, 1,0));
    vecs.push_back(mk(0,1,0,16'h12F4,1, 1,1,4'h4,1, 1,0));
    vecs.push_back(mk(0,1,0,16'h12F4,1, 0,0,4'h0,0, 1,1));
    vecs.push_back(mk(0,1,0,16'h12F4,1, 0,0,4'h0,0, 0,0));
    // all blank: straight to DONE, never valid
    vecs.push_back(mk(0,1,1,16'hFFFF,1, 0,0,4'h0,0, 1,1));
    vecs.push_back(mk(0,1,0,16'hFFFF,1, 0,0,4'h0,0, 0,0));
    // ready 1,0,0,1 stalls and a 3-cycle ce gap
    vecs.push_back(mk(0,1,1,16'h1234,0, 1,1,4'h1,0, 1,0));
    vecs.push_back(mk(0,1,0,16'h1234,1, 1,1,4'h2,0, 1,0));
    vecs.push_back(mk(0,1,0,16'h1234,0, 1,1,4'h2,0, 1,0));
    vecs.push_back(mk(0,1,0,16'h1234,0, 1,1,4'h2,0, 1,0));
    vecs.push_back(mk(0,1,0,16'h1234,1, 1,1,4'h3,0, 1,0));
    vecs.push_back(mk(0,0,0,16'h1234,1, 1,1,4'h3,0, 1,0));
    vecs.push_back(mk(0,0,1,16'h1234,1, 1,1,4'h3,0, 1,0));
    vecs.push_back(mk(0,0,0,16'h1234,1, 1,1,4'h3,0, 1,0));
    vecs.push_back(mk(0,1,0,16'h1234,1, 1,1,4'h4,1, 1,0));
    vecs.push_back(mk(0,1,0,16'h1234,1, 0,0,4'h0,0, 1,1));
    vecs.push_back(mk(0,1,0,16'h1234,1, 0,0,4'h0,0, 0,0));
    // load with ce low in IDLE is not honoured
    vecs.push_back(mk(0,0,1,16'h1234,1, 0,0,4'h0,0, 0,0));
    vecs.push_back(mk(0,1,0,16'h1234,1, 0,0,4'h0,0, 0,0));
    // load of 5678 while sending 1234, including on the final transfer and in DONE
    vecs.push_back(mk(0,1,1,16'h1234,1, 1,1,4'h1,0, 1,0));
    vecs.push_back(mk(0,1,1,16'h5678,1, 1,1,4'h2,0, 1,0));
    vecs.push_back(mk(0,1,1,16'h5678,1, 1,1,4'h3,0, 1,0));
    vecs.push_back(mk(0,1,1,16'h5678,1, 1,1,4'h4,1, 1,0));
    vecs.push_back(mk(0,1,1,16'h5678,1, 0,0,4'h0,0, 1,1));
    vecs.push_back(mk(0,1,1,16'h5678,1, 0,0,4'h0,0, 0,0));
    // reset after the 2nd transfer, then 9ABC
    vecs.push_back(mk(0,1,0,16'h5678,1, 0,0,4'h0,0, 0,0));
    vecs.push_back(mk(0,1,1,16'h1234,1, 1,1,4'h1,0, 1,0));
    vecs.push_back(mk(0,1,0,16'h1234,1, 1,1,4'h2,0, 1,0));
    vecs.push_back(mk(0,1,0,16'h1234,1, 1,1,4'h3,0, 1,0));
    vecs.push_back(mk(1,1,0,16'h1234,1, 0,1,4'h0,0, 0,0));
    vecs.push_back(mk(0,1,1,16'h9ABC,1, 1,1,4'h9,0, 1,0));
    vecs.push_back(mk(0,1,0,16'h9ABC,1, 1,1,4'hA,0, 1,0));
    vecs.push_back(mk(0,1,0,16'h9ABC,1, 1,1,4'hB,0, 1,0));
    vecs.push_back(mk(0,1,0,16'h9ABC,1, 1,1,4'hC,1, 1,0));
    vecs.push_back(mk(0,1,0,16'h9ABC,1, 0,0,4'h0,0, 1,1));
    vecs.push_back(mk(0,1,0,16'h9ABC,1, 0,0,4'h0,0, 0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; ce = vecs[i].ce; load = vecs[i].load; code_in = vecs[i].code;
      if_a.dig_ready = vecs[i].rdy; if_b.dig_ready = vecs[i].rdy;
      step();
      chk($sformatf("v%0d valid", i), {31'd0, if_a.dig_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("v%0d busy", i),  {31'd0, busy_a},         {31'd0, vecs[i].eb});
      chk($sformatf("v%0d done", i),  {31'd0, done_a},         {31'd0, vecs[i].edn});
      if (vecs[i].dchk) begin
        chk($sformatf("v%0d data", i), {28'd0, if_a.dig_data}, {28'd0, vecs[i].ed});
        chk($sformatf("v%0d last", i), {31'd0, if_a.dig_last}, {31'd0, vecs[i].el});
      end
    end

    // newest-first build: 1234 -> 4,3,2,1, last with the 1
    exp_b[0] = 4'h4; exp_b[1] = 4'h3; exp_b[2] = 4'h2; exp_b[3] = 4'h1;
    got_b[0] = 4'h0; got_b[1] = 4'h0; got_b[2] = 4'h0; got_b[3] = 4'h0;
    got_last = 4'h0;
    n_b = 0; seen_done = 1'b0;
    rst = 1'b0; ce = 1'b1; load = 1'b1; code_in = 16'h1234;
    if_a.dig_ready = 1'b1; if_b.dig_ready = 1'b1;
    step();
    load = 1'b0;
    for (int c = 0; c < 12 && !seen_done; c++) begin
      if (if_b.dig_valid) begin
        if (n_b < 4) begin
          got_b[n_b]    = if_b.dig_data;
          got_last[n_b] = if_b.dig_last;
        end
        n_b++;
      end
      if (done_b) seen_done = 1'b1;
      else step();
    end
    chk("rev done seen", {31'd0, seen_done}, 32'd1);
    chk("rev count", n_b, 32'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("rev data%0d", k), {28'd0, got_b[k]}, {28'd0, exp_b[k]});
    chk("rev last flags", {28'd0, got_last}, 32'h8);
    step();
    chk("rev busy after", {31'd0, busy_b}, 32'd0);
    chk("rev done width", {31'd0, done_b}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
